toom8_pointwise_sched: RTL and testbench

TOOM8_POINTWISE_SCHED -- requirements
Module: toom8_pointwise_sched

---
 rtl/toom8_pkg.sv | 22 ++
 rtl/toom8_credit_ctr.sv | 24 ++
 rtl/toom8_pointwise_sched.sv | 131 +++++++++++++
 tb/tb_toom8_pointwise_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toom8_pkg.sv
// Shared constants and types for the Toom-8 pointwise product scheduler.
package toom8_pkg;

    localparam int NUM_PTS = 15;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    // Bit width of each pointwise product p0..p14
    localparam int PROD_W [NUM_PTS] = '{258, 264, 264, 278, 278, 288, 288, 296,
                                        296, 298, 298, 300, 300, 310, 258};

    function automatic int prod_width(input int idx);
        return PROD_W[idx];
    endfunction

endpackage

// File: rtl/toom8_credit_ctr.sv
// Counts multiplier requests in flight; simultaneous inc and dec cancel out.
module toom8_credit_ctr #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/toom8_pointwise_sched.sv
// Issues the 15 pointwise multiplications to a shared multiplier with bounded
// outstanding requests and writes in-order results back to the pointwise bank.
module toom8_pointwise_sched #(
    parameter int NUM_PTS   = toom8_pkg::NUM_PTS,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       mul_req_valid,
    input  logic                       mul_req_ready,
    output logic [toom8_pkg::IDX_W-1:0] mul_req_idx,
    input  logic                       mul_rsp_valid,
    input  logic [toom8_pkg::IDX_W-1:0] mul_rsp_idx,
    output logic                       wb_en,
    output logic [toom8_pkg::IDX_W-1:0] wb_idx,
    output logic                       err
);
    import toom8_pkg::*;

    localparam int               CNT_W    = $clog2(MAX_OUTST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);

    sched_state_t     state, state_nxt;
    logic [IDX_W-1:0] issue_cnt, issue_nxt;
    logic [IDX_W-1:0] rcv_cnt, rcv_nxt;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_nxt;
    logic [CNT_W-1:0] outstanding;
    logic             err_q, err_nxt;
    logic             wb_en_q, wb_en_nxt;
    logic             active, kill, start_acc, cnt_clr;
    logic             req_acc, rsp_match, rsp_acc, rsp_bad;

    assign active    = (state == ISSUE) || (state == DRAIN);
    assign kill      = abort && (state != IDLE);
    assign start_acc = (state == IDLE) && start && !abort;
    assign cnt_clr   = start_acc || kill;

    assign mul_req_valid = (state == ISSUE) && (outstanding < CNT_W'(MAX_OUTST));
    assign mul_req_idx   = (state == ISSUE) ? issue_cnt : '0;

    // Responses must arrive strictly in issue order; anything else is a protocol error
    assign req_acc   = mul_req_valid && mul_req_ready && !kill;
    assign rsp_match = mul_rsp_valid && (outstanding != '0) && (mul_rsp_idx == rcv_cnt);
    assign rsp_acc   = active && rsp_match && !kill;
    assign rsp_bad   = active && mul_rsp_valid && !rsp_match && !kill;

    toom8_credit_ctr #(
        .MAX(MAX_OUTST)
    ) u_credit (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (req_acc),
        .dec  (rsp_acc),
        .count(outstanding)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            err_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_idx_q  <= '0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_nxt;
            rcv_cnt   <= rcv_nxt;
            err_q     <= err_nxt;
            wb_en_q   <= wb_en_nxt;
            wb_idx_q  <= wb_idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue_nxt  = req_acc ? issue_cnt + 1'b1 : issue_cnt;
        rcv_nxt    = rsp_acc ? rcv_cnt + 1'b1 : rcv_cnt;
        err_nxt    = err_q || rsp_bad;
        wb_en_nxt  = rsp_acc;
        wb_idx_nxt = rsp_acc ? mul_rsp_idx : '0;

        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_nxt = ISSUE;
                    issue_nxt = '0;
                    rcv_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            ISSUE: begin
                if (req_acc && (issue_cnt == LAST_IDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_acc && (rcv_cnt == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                issue_nxt = '0;
                rcv_nxt   = '0;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort overrides every other transition and discards any pending write
        if (kill) begin
            state_nxt  = IDLE;
            issue_nxt  = '0;
            rcv_nxt    = '0;
            wb_en_nxt  = 1'b0;
            wb_idx_nxt = '0;
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE) && !abort;
    assign wb_en  = wb_en_q && !kill;
    assign wb_idx = wb_idx_q;
    assign err    = err_q;

endmodule

// File: tb/tb_toom8_pointwise_sched.sv
// Self-checking bench for toom8_pointwise_sched: vector table, hand-written
// abort/reset sequences and randomized schedules against a behavioural model.
module tb_toom8_pointwise_sched;

    localparam int NP = 15;
    localparam int MO = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       mul_req_valid;
    logic       mul_req_ready;
    logic [3:0] mul_req_idx;
    logic       mul_rsp_valid;
    logic [3:0] mul_rsp_idx;
    logic       wb_en;
    logic [3:0] wb_idx;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int st;
        int ab;
        int rdy;
        int rv;
        int ri;
        int eBusy;
        int eReqV;
        int eReqIdx;
        int eWb;
        int eWbIdx;
        int eDone;
        int eErr;
    } vec_t;

    vec_t tbl [16];

    toom8_pointwise_sched #(
        .NUM_PTS  (NP),
        .MAX_OUTST(MO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .mul_req_valid(mul_req_valid),
        .mul_req_ready(mul_req_ready),
        .mul_req_idx  (mul_req_idx),
        .mul_rsp_valid(mul_rsp_valid),
        .mul_rsp_idx  (mul_rsp_idx),
        .wb_en        (wb_en),
        .wb_idx       (wb_idx),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later
    task automatic applyStimulus(input int st, input int ab, input int rdy,
                                 input int rv, input int ri);
        start         = st[0];
        abort         = ab[0];
        mul_req_ready = rdy[0];
        mul_rsp_valid = rv[0];
        mul_rsp_idx   = ri[3:0];
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkVec(input vec_t v, input string tag);
        checkOutput({tag, " busy"}, int'(busy), v.eBusy);
        checkOutput({tag, " req_valid"}, int'(mul_req_valid), v.eReqV);
        if (v.eReqV != 0) checkOutput({tag, " req_idx"}, int'(mul_req_idx), v.eReqIdx);
        checkOutput({tag, " wb_en"}, int'(wb_en), v.eWb);
        if (v.eWb != 0) checkOutput({tag, " wb_idx"}, int'(wb_idx), v.eWbIdx);
        checkOutput({tag, " done"}, int'(done), v.eDone);
        checkOutput({tag, " err"}, int'(err), v.eErr);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
        checkOutput({tag, " req_valid"}, int'(mul_req_valid), 0);
        checkOutput({tag, " req_idx"}, int'(mul_req_idx), 0);
        checkOutput({tag, " wb_en"}, int'(wb_en), 0);
        checkOutput({tag, " wb_idx"}, int'(wb_idx), 0);
        checkOutput({tag, " err"}, int'(err), 0);
    endtask

    // Model: request k is index k; at most MO unanswered; each response comes
    // back in order after its latency and is written back one cycle later.
    task automatic runSchedule(input int readyMode, input int latMin, input int latMax,
                               input int rstInDrain, input string tag);
        int dueQ[$];
        int issued   = 0;
        int sent     = 0;
        int lastDue  = -1;
        int prevV    = 0;
        int prevIdx  = 0;
        int obsWb    = 0;
        int obsDone  = 0;
        int finished = 0;
        int rstHit   = 0;
        int rdy, rv, ri, st, expV, expDone, due;

        applyStimulus(1, 0, 0, 0, 0);
        checkOutput({tag, " idle before start"}, int'(busy), 0);
        nextCycle();

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rstInDrain != 0 && issued == NP) begin
                rst = 1'b1;
                applyStimulus(1, 0, 1, 0, 0);
                nextCycle();
                checkResetValues({tag, " after rst"});
                rst = 1'b0;
                applyStimulus(0, 0, 0, 0, 0);
                nextCycle();
                checkOutput({tag, " idle after rst"}, int'(busy), 0);
                rstHit = 1;
                break;
            end

            case (readyMode)
                0:       rdy = 1;
                1:       rdy = (cyc % 2 == 0) ? 1 : 0;
                default: rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
            endcase
            st = (readyMode == 2 && $urandom_range(0, 7) == 0) ? 1 : 0;
            rv = 0;
            ri = 0;
            if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
                rv = 1;
                ri = sent;
            end

            applyStimulus(st, 0, rdy, rv, ri);
            expV    = (issued < NP && (issued - sent) < MO) ? 1 : 0;
            expDone = (prevV != 0 && prevIdx == NP - 1) ? 1 : 0;
            checkOutput({tag, " busy"}, int'(busy), 1);
            checkOutput({tag, " req_valid"}, int'(mul_req_valid), expV);
            if (expV != 0) checkOutput({tag, " req_idx"}, int'(mul_req_idx), issued);
            checkOutput({tag, " wb_en"}, int'(wb_en), prevV);
            if (prevV != 0) checkOutput({tag, " wb_idx"}, int'(wb_idx), prevIdx);
            checkOutput({tag, " done"}, int'(done), expDone);
            checkOutput({tag, " err"}, int'(err), 0);
            obsWb   += int'(wb_en);
            obsDone += int'(done);

            if (expV != 0 && rdy != 0) begin
                due = cyc + $urandom_range(latMin, latMax);
                if (due <= lastDue) due = lastDue + 1;
                dueQ.push_back(due);
                lastDue = due;
                issued++;
            end
            prevV   = rv;
            prevIdx = ri;
            if (rv != 0) begin
                void'(dueQ.pop_front());
                sent++;
            end
            nextCycle();
            if (expDone != 0) begin
                finished = 1;
                break;
            end
        end

        if (rstInDrain != 0) begin
            checkOutput({tag, " reached drain"}, rstHit, 1);
        end else begin
            checkOutput({tag, " completed in budget"}, finished, 1);
            checkOutput({tag, " wb count"}, obsWb, NP);
            checkOutput({tag, " done count"}, obsDone, 1);
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput({tag, " idle after done"}, int'(busy), 0);
            checkOutput({tag, " done one cycle"}, int'(done), 0);
            nextCycle();
        end
    endtask

    initial begin
        //        st ab rdy rv ri  busy reqv ridx wb wbi done err
        tbl[0]  = '{1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0,  1, 1, 2, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0,  1, 1, 3, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 0,  1, 1, 4, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 2,  1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0,  1, 1, 5, 1, 1, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0,  1, 1, 5, 0, 0, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1};
        tbl[13] = '{0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        checkResetValues("reset");
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        nextCycle();

        $display("[TB] vector table: credit limit, in-order error, abort, err clear");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].st, tbl[i].ab, tbl[i].rdy, tbl[i].rv, tbl[i].ri);
            checkVec(tbl[i], $sformatf("vec%0d", i));
            nextCycle();
        end

        $display("[TB] abort after six issues");
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput($sformatf("abort issue%0d idx", k), int'(mul_req_idx), k);
            nextCycle();
        end
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("abort credit stall", int'(mul_req_valid), 0);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("abort issue4 idx", int'(mul_req_idx), 4);
        checkOutput("abort wb0", int'(wb_en), 1);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 2);
        checkOutput("abort issue5 valid", int'(mul_req_valid), 1);
        checkOutput("abort issue5 idx", int'(mul_req_idx), 5);
        checkOutput("abort wb1 idx", int'(wb_idx), 1);
        nextCycle();
        applyStimulus(0, 1, 1, 1, 3);
        checkOutput("abort cycle wb suppressed", int'(wb_en), 0);
        checkOutput("abort cycle no done", int'(done), 0);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, (k < 2) ? 1 : 0, 3 + k);
            checkOutput($sformatf("post-abort%0d busy", k), int'(busy), 0);
            checkOutput($sformatf("post-abort%0d req_valid", k), int'(mul_req_valid), 0);
            checkOutput($sformatf("post-abort%0d wb_en", k), int'(wb_en), 0);
            checkOutput($sformatf("post-abort%0d done", k), int'(done), 0);
            checkOutput($sformatf("post-abort%0d err", k), int'(err), 0);
            nextCycle();
        end

        $display("[TB] full schedules");
        runSchedule(0, 3, 3, 0, "fixed3");
        runSchedule(1, 3, 3, 0, "toggle");
        runSchedule(0, 3, 3, 1, "rstdrain");
        for (int r = 0; r < 4; r++) begin
            runSchedule(2, 1, 6, 0, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
